// File: rtl/mem_phase_controller_if.sv
// Bus bundle for the image-RAM phase controller: writer, downsampler and reader
// ports in, shared RAM port, start pulses and status out.
interface mem_phase_controller_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              wr_wen;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_fin;
    logic              proc_wen;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_data;
    logic              proc_fin;
    logic [ADDR_W-1:0] tx_addr;
    logic              tx_fin;
    logic              restart;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              proc_start;
    logic              tx_start;
    logic              wr_clear;
    logic [2:0]        phase;
    logic              done;
    logic              error;

    modport master (
        output wr_wen, wr_addr, wr_data, wr_fin,
        output proc_wen, proc_addr, proc_data, proc_fin,
        output tx_addr, tx_fin, restart,
        input  ram_wen, ram_addr, ram_din,
        input  proc_start, tx_start, wr_clear, phase, done, error
    );

    modport slave (
        input  wr_wen, wr_addr, wr_data, wr_fin,
        input  proc_wen, proc_addr, proc_data, proc_fin,
        input  tx_addr, tx_fin, restart,
        output ram_wen, ram_addr, ram_din,
        output proc_start, tx_start, wr_clear, phase, done, error
    );
endinterface

// File: rtl/mem_phase_controller.sv
// Sequences LOAD -> PROC -> SEND -> DONE over one shared image RAM, muxing the
// owning block's port onto a registered RAM port, with a per-phase watchdog.
module mem_phase_controller #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WDOG_W = 24
) (
    input logic                    clk,
    input logic                    rst_n,
    mem_phase_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        PROC  = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Expiry fires on the edge that would bring the count to all-ones.
    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;
    localparam logic [WDOG_W-1:0] WDOG_EXP = WDOG_MAX - WDOG_W'(1);

    state_t            st;
    logic [WDOG_W-1:0] wdog;
    logic              wr_fin_q;
    logic              first;
    logic              ram_wen_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_din_r;
    logic              proc_start_r;
    logic              tx_start_r;
    logic              wr_clear_r;
    logic              done_r;
    logic              error_r;
    logic              wr_fin_rise;

    assign wr_fin_rise = bus.wr_fin & ~wr_fin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= LOAD;
            wdog         <= '0;
            wr_fin_q     <= 1'b1;
            first        <= 1'b0;
            ram_wen_r    <= 1'b0;
            ram_addr_r   <= '0;
            ram_din_r    <= '0;
            proc_start_r <= 1'b0;
            tx_start_r   <= 1'b0;
            wr_clear_r   <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            wr_fin_q     <= bus.wr_fin;
            first        <= 1'b0;
            proc_start_r <= 1'b0;
            tx_start_r   <= 1'b0;
            wr_clear_r   <= 1'b0;
            ram_wen_r    <= 1'b0;
            ram_addr_r   <= '0;
            ram_din_r    <= '0;
            if (bus.restart) begin
                st         <= LOAD;
                first      <= 1'b1;
                wdog       <= '0;
                done_r     <= 1'b0;
                error_r    <= 1'b0;
                wr_clear_r <= 1'b1;
            end else begin
                case (st)
                    LOAD: begin
                        ram_wen_r  <= bus.wr_wen;
                        ram_addr_r <= bus.wr_addr;
                        ram_din_r  <= bus.wr_data;
                        if (wr_fin_rise) begin
                            st           <= PROC;
                            first        <= 1'b1;
                            wdog         <= '0;
                            proc_start_r <= 1'b1;
                        end
                    end
                    PROC: begin
                        ram_wen_r  <= bus.proc_wen;
                        ram_addr_r <= bus.proc_addr;
                        ram_din_r  <= bus.proc_data;
                        if (wdog == WDOG_EXP) begin
                            st      <= ERROR;
                            wdog    <= '0;
                            error_r <= 1'b1;
                        end else if (!first && bus.proc_fin) begin
                            st         <= SEND;
                            first      <= 1'b1;
                            wdog       <= '0;
                            tx_start_r <= 1'b1;
                        end else if (wdog != WDOG_MAX) begin
                            wdog <= wdog + WDOG_W'(1);
                        end
                    end
                    SEND: begin
                        ram_addr_r <= bus.tx_addr;
                        if (wdog == WDOG_EXP) begin
                            st      <= ERROR;
                            wdog    <= '0;
                            error_r <= 1'b1;
                        end else if (!first && bus.tx_fin) begin
                            st     <= DONE;
                            wdog   <= '0;
                            done_r <= 1'b1;
                        end else if (wdog != WDOG_MAX) begin
                            wdog <= wdog + WDOG_W'(1);
                        end
                    end
                    DONE, ERROR: begin
                    end
                    default: begin
                        st   <= LOAD;
                        wdog <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.phase      = st;
    assign bus.ram_wen    = ram_wen_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_din    = ram_din_r;
    assign bus.proc_start = proc_start_r;
    assign bus.tx_start   = tx_start_r;
    assign bus.wr_clear   = wr_clear_r;
    assign bus.done       = done_r;
    assign bus.error      = error_r;
endmodule

// File: tb/tb_mem_phase_controller.sv
// Randomized and directed bench for mem_phase_controller: a phase-level reference
// model queues the expected outputs, a monitor compares after each clock edge.
module tb_mem_phase_controller;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned WDOG_W  = 4;
    localparam int          TIMEOUT = (1 << WDOG_W) - 1;

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              ps;
        logic              ts;
        logic              wc;
        logic [2:0]        phase;
        logic              done;
        logic              error;
    } rec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    rec_t sb[$];

    int   m_phase;
    int   m_cycles;
    logic m_prev_fin;
    logic m_done;
    logic m_error;

    mem_phase_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_phase_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDOG_W(WDOG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t dut_rec();
        rec_t r;
        r.wen   = bus.ram_wen;
        r.addr  = bus.ram_addr;
        r.din   = bus.ram_din;
        r.ps    = bus.proc_start;
        r.ts    = bus.tx_start;
        r.wc    = bus.wr_clear;
        r.phase = bus.phase;
        r.done  = bus.done;
        r.error = bus.error;
        return r;
    endfunction

    task automatic report(input string name, input rec_t a, input rec_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t act ph=%0d wen=%b addr=%h din=%h ps=%b ts=%b wc=%b done=%b err=%b | exp ph=%0d wen=%b addr=%h din=%h ps=%b ts=%b wc=%b done=%b err=%b",
                     name, $time, a.phase, a.wen, a.addr, a.din, a.ps, a.ts, a.wc, a.done, a.error,
                     e.phase, e.wen, e.addr, e.din, e.ps, e.ts, e.wc, e.done, e.error);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_cycles   = 0;
        m_prev_fin = 1'b1;
        m_done     = 1'b0;
        m_error    = 1'b0;
    endtask

    // Phase-level rules: who owns the RAM, which fin input counts, and how long a phase may last.
    task automatic model_step(output rec_t e);
        e = '0;
        if (bus.restart) begin
            m_phase  = 0;
            m_cycles = 0;
            m_done   = 1'b0;
            m_error  = 1'b0;
            e.wc     = 1'b1;
        end else if (m_phase == 0) begin
            e.wen  = bus.wr_wen;
            e.addr = bus.wr_addr;
            e.din  = bus.wr_data;
            if (bus.wr_fin && !m_prev_fin) begin
                m_phase  = 1;
                m_cycles = 0;
                e.ps     = 1'b1;
            end
        end else if (m_phase == 1 || m_phase == 2) begin
            if (m_phase == 1) begin
                e.wen  = bus.proc_wen;
                e.addr = bus.proc_addr;
                e.din  = bus.proc_data;
            end else begin
                e.addr = bus.tx_addr;
            end
            if (m_cycles + 1 >= TIMEOUT) begin
                m_phase  = 4;
                m_cycles = 0;
                m_error  = 1'b1;
            end else if (m_cycles > 0 && m_phase == 1 && bus.proc_fin) begin
                m_phase  = 2;
                m_cycles = 0;
                e.ts     = 1'b1;
            end else if (m_cycles > 0 && m_phase == 2 && bus.tx_fin) begin
                m_phase  = 3;
                m_cycles = 0;
                m_done   = 1'b1;
            end else begin
                m_cycles++;
            end
        end
        m_prev_fin = bus.wr_fin;
        e.phase    = 3'(m_phase);
        e.done     = m_done;
        e.error    = m_error;
    endtask

    task automatic drive_cycle();
        rec_t e;
        model_step(e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            rec_t e;
            e = sb.pop_front();
            report("sb_cycle", dut_rec(), e);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.wr_wen = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_fin = 1'b1;
        bus.proc_wen = 0; bus.proc_addr = '0; bus.proc_data = '0; bus.proc_fin = 0;
        bus.tx_addr = '0; bus.tx_fin = 0; bus.restart = 0;
        model_reset();
        repeat (2) @(negedge clk);
        report("reset_state", dut_rec(), '0);
        rst_n = 1'b1;

        // wr_fin high since reset must not count as an edge
        run(3);
        bus.wr_fin = 1'b0;
        run(1);
        for (int i = 0; i < 4; i++) begin
            bus.wr_wen  = 1'b1;
            bus.wr_addr = 16'(i);
            bus.wr_data = 8'($urandom);
            run(1);
        end
        bus.wr_wen = 1'b0;
        bus.wr_fin = 1'b1;
        run(1);
        bus.wr_wen = 1'b1; bus.wr_addr = 16'h00aa; bus.wr_data = 8'h5a;
        bus.proc_wen = 1'b1; bus.proc_addr = 16'h0042; bus.proc_data = 8'hc3;
        run(3);
        bus.wr_wen = 1'b0; bus.proc_wen = 1'b0;
        bus.proc_fin = 1'b1;
        run(1);
        bus.proc_fin = 1'b0;
        bus.proc_wen = 1'b1; bus.tx_addr = 16'h1234;
        run(3);
        bus.proc_wen = 1'b0;
        bus.tx_fin = 1'b1;
        run(1);
        bus.tx_fin = 1'b0;
        run(3);

        // stale wr_fin across restart, then watchdog expiry in PROC
        bus.restart = 1'b1; run(1); bus.restart = 1'b0;
        run(3);
        bus.wr_fin = 1'b0; run(1);
        bus.wr_fin = 1'b1; run(1);
        run(18);
        bus.restart = 1'b1; run(1); bus.restart = 1'b0;
        run(2);

        // restart and proc_fin in the same cycle
        bus.wr_fin = 1'b0; run(1);
        bus.wr_fin = 1'b1; run(1);
        run(2);
        bus.proc_fin = 1'b1; bus.restart = 1'b1; run(1);
        bus.restart = 1'b0; bus.proc_fin = 1'b0;
        run(2);

        // fin inputs already high on phase entry
        bus.wr_fin = 1'b0; run(1);
        bus.proc_fin = 1'b1; bus.wr_fin = 1'b1; run(3);
        bus.proc_fin = 1'b0; bus.tx_fin = 1'b1; run(3);
        bus.tx_fin = 1'b0;
        bus.restart = 1'b1; run(1); bus.restart = 1'b0;

        // asynchronous reset while in SEND
        bus.wr_fin = 1'b0; run(1);
        bus.wr_fin = 1'b1; run(1);
        bus.proc_fin = 1'b1; run(2);
        bus.proc_fin = 1'b0; bus.tx_addr = 16'h1234;
        run(2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 report("async_reset", dut_rec(), '0);
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            bus.wr_wen    = 1'($urandom_range(0, 1));
            bus.wr_addr   = 16'($urandom);
            bus.wr_data   = 8'($urandom);
            bus.proc_wen  = 1'($urandom_range(0, 1));
            bus.proc_addr = 16'($urandom);
            bus.proc_data = 8'($urandom);
            bus.tx_addr   = 16'($urandom);
            if ($urandom_range(0, 99) < 15) bus.wr_fin = ~bus.wr_fin;
            bus.proc_fin  = ($urandom_range(0, 99) < 12);
            bus.tx_fin    = ($urandom_range(0, 99) < 12);
            bus.restart   = ($urandom_range(0, 99) < 3);
            drive_cycle();
        end
        bus.restart = 1'b0;
        repeat (2) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
